nes_palette_arbiter: RTL and testbench

- Owns the 32-entry x 6-bit PPU palette RAM and shares its single port between two requesters: the render pixel pipeline (one lookup per ppu_clock) and the CPU ($2007 accesses in the $3F00-$3F1F range).
- Sits between the background/sprite pixel mux and the palette-to-RGB stage.
- Emits nes_color with pixel coordinates and VGA strobes delay-matched to it.

---
 rtl/nes_ppu_pkg.sv | 30 +++
 rtl/nes_palette_arbiter_if.sv | 24 ++
 rtl/nes_palette_ram.sv | 36 +++
 rtl/nes_palette_arbiter.sv | 165 ++++++++++++++++
 tb/tb_nes_palette_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nes_ppu_pkg.sv
// rtl/nes_ppu_pkg.sv - shared types, constants and address mirroring for the palette arbiter
// Contents: palette_addr_t, nes_color_t, PALETTE_DEPTH, arb_state_e,
//           POWERUP_PALETTE (used when NES_PALETTE_RESET_INIT_EN is defined), mirror_addr().
package nes_ppu_pkg;

   localparam int PALETTE_DEPTH = 32;

   typedef logic [4:0] palette_addr_t;
   typedef logic [5:0] nes_color_t;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      WAIT,
      ACK
   } arb_state_e;

   localparam nes_color_t POWERUP_PALETTE [PALETTE_DEPTH] = '{
      6'h09, 6'h01, 6'h00, 6'h01, 6'h00, 6'h02, 6'h02, 6'h0D,
      6'h08, 6'h10, 6'h08, 6'h24, 6'h00, 6'h00, 6'h04, 6'h2C,
      6'h09, 6'h01, 6'h34, 6'h03, 6'h00, 6'h04, 6'h00, 6'h14,
      6'h08, 6'h3A, 6'h00, 6'h02, 6'h00, 6'h20, 6'h2C, 6'h08
   };

   // Sprite backdrop entries $10/$14/$18/$1C are the same cells as $00/$04/$08/$0C.
   function automatic palette_addr_t mirror_addr(input palette_addr_t addr);
      mirror_addr = (addr[4] && (addr[1:0] == 2'b00)) ? {1'b0, addr[3:0]} : addr;
   endfunction

endpackage

// File: rtl/nes_palette_arbiter_if.sv
// rtl/nes_palette_arbiter_if.sv - CPU palette access handshake bundle
// Signals: cpu_req/cpu_we/cpu_addr/cpu_wdata (CPU -> arbiter), cpu_ack/cpu_rdata (arbiter -> CPU).
// Modports: master = CPU side, slave = arbiter side.
interface nes_palette_arbiter_if;
   import nes_ppu_pkg::*;

   logic          cpu_req;
   logic          cpu_we;
   palette_addr_t cpu_addr;
   nes_color_t    cpu_wdata;
   logic          cpu_ack;
   nes_color_t    cpu_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata
   );

endinterface

// File: rtl/nes_palette_ram.sv
// rtl/nes_palette_ram.sv - 32x6 single-port palette memory, synchronous write, registered read
// Ports: i_clk, i_resetn (sync active-low, clears read register only), i_we, i_re,
//        i_addr, i_wdata, o_rdata (registered, updates only when i_re is high).
module nes_palette_ram
   import nes_ppu_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_resetn,
   input  logic          i_we,
   input  logic          i_re,
   input  palette_addr_t i_addr,
   input  nes_color_t    i_wdata,
   output nes_color_t    o_rdata
);

   nes_color_t r_mem [PALETTE_DEPTH];
   nes_color_t r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read together with write returns the new data (forced-slot write glitch pixel).
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= i_we ? i_wdata : r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/nes_palette_arbiter.sv
// rtl/nes_palette_arbiter.sv - shares the palette RAM port between the render pipeline and the CPU
// Ports: ppu_clock, reset_n (sync active-low), rendering_enabled, render_valid, render_index,
//        x, y, vga_we, vga_swap_buffers (render side, aligned); cpu (slave handshake bundle);
//        nes_color, x_out, y_out, vga_we_out, vga_swap_buffers_out (1-cycle delayed); busy.
// Optional: NES_PALETTE_RESET_INIT_EN loads POWERUP_PALETTE after reset (INIT state, busy high).
module nes_palette_arbiter
   import nes_ppu_pkg::*;
#(
   parameter int MAX_WAIT = 341,
   parameter int WAIT_W   = 9
)(
   input  logic                  ppu_clock,
   input  logic                  reset_n,
   input  logic                  rendering_enabled,
   input  logic                  render_valid,
   input  palette_addr_t         render_index,
   input  logic [7:0]            x,
   input  logic [7:0]            y,
   input  logic                  vga_we,
   input  logic                  vga_swap_buffers,
   nes_palette_arbiter_if.slave  cpu,
   output nes_color_t            nes_color,
   output logic [7:0]            x_out,
   output logic [7:0]            y_out,
   output logic                  vga_we_out,
   output logic                  vga_swap_buffers_out,
   output logic                  busy
);

   localparam logic [WAIT_W-1:0] L_MAX_WAIT = WAIT_W'(MAX_WAIT);

   arb_state_e        r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_show_ram;
   nes_color_t        r_color_hold;
   logic              r_ack;
   logic              r_ack_rd;
   nes_color_t        r_rdata_hold;
`ifdef NES_PALETTE_RESET_INIT_EN
   palette_addr_t     r_init_addr;
`endif

   logic          w_slot;
   logic          w_cpu_go;
   logic          w_in_init;
   logic          w_ram_we;
   logic          w_ram_re;
   palette_addr_t w_ram_addr;
   nes_color_t    w_ram_wdata;
   nes_color_t    w_ram_rdata;

   assign w_slot    = rendering_enabled & render_valid;
   // CPU goes in a free cycle, or steals the render slot once it has waited a full scanline.
   assign w_cpu_go  = (r_state == WAIT) && (!w_slot || (r_wait_cnt == L_MAX_WAIT));
   assign w_in_init = (r_state == INIT);

   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_re    = 1'b0;
      w_ram_addr  = mirror_addr(render_index);
      w_ram_wdata = cpu.cpu_wdata;
      if (!reset_n) begin
         w_ram_we = 1'b0;
`ifdef NES_PALETTE_RESET_INIT_EN
      end else if (w_in_init) begin
         w_ram_we    = 1'b1;
         w_ram_addr  = r_init_addr;
         w_ram_wdata = POWERUP_PALETTE[r_init_addr];
`endif
      end else if (w_cpu_go) begin
         w_ram_addr = mirror_addr(cpu.cpu_addr);
         w_ram_we   = cpu.cpu_we;
         // Forced slot also drives the read register so the glitch pixel reaches nes_color.
         w_ram_re   = !cpu.cpu_we || w_slot;
      end else if (w_slot) begin
         w_ram_re = 1'b1;
      end
   end

   nes_palette_ram u_ram (
      .i_clk    (ppu_clock),
      .i_resetn (reset_n),
      .i_we     (w_ram_we),
      .i_re     (w_ram_re),
      .i_addr   (w_ram_addr),
      .i_wdata  (w_ram_wdata),
      .o_rdata  (w_ram_rdata)
   );

   // The RAM read register is shared with CPU reads, so the render output follows it only
   // after a render (or forced) read and otherwise replays the last shown colour.
   assign nes_color     = r_show_ram ? w_ram_rdata : r_color_hold;
   assign cpu.cpu_ack   = r_ack;
   assign cpu.cpu_rdata = r_ack_rd ? w_ram_rdata : r_rdata_hold;
   assign busy          = w_in_init;

   always_ff @(posedge ppu_clock) begin
      if (!reset_n) begin
         x_out                <= '0;
         y_out                <= '0;
         vga_we_out           <= 1'b0;
         vga_swap_buffers_out <= 1'b0;
         r_show_ram           <= 1'b0;
         r_color_hold         <= '0;
         r_rdata_hold         <= '0;
      end else begin
         x_out                <= x;
         y_out                <= y;
         vga_we_out           <= vga_we;
         vga_swap_buffers_out <= vga_swap_buffers;
         r_show_ram           <= w_slot && !w_in_init;
         r_color_hold         <= (w_slot && w_in_init) ? '0 : nes_color;
         r_rdata_hold         <= cpu.cpu_rdata;
      end
   end

   always_ff @(posedge ppu_clock) begin
      if (!reset_n) begin
`ifdef NES_PALETTE_RESET_INIT_EN
         r_state     <= INIT;
         r_init_addr <= '0;
`else
         r_state     <= IDLE;
`endif
         r_wait_cnt  <= '0;
         r_ack       <= 1'b0;
         r_ack_rd    <= 1'b0;
      end else begin
         r_ack    <= w_cpu_go;
         r_ack_rd <= w_cpu_go && !cpu.cpu_we;
         case (r_state)
            INIT: begin
`ifdef NES_PALETTE_RESET_INIT_EN
               r_init_addr <= r_init_addr + 5'd1;
               if (r_init_addr == 5'(PALETTE_DEPTH - 1)) begin
                  r_state <= IDLE;
               end
`else
               r_state <= IDLE;
`endif
            end
            IDLE: begin
               if (cpu.cpu_req) begin
                  r_state    <= WAIT;
                  r_wait_cnt <= '0;
               end
            end
            WAIT: begin
               if (w_cpu_go) begin
                  r_state <= ACK;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ACK: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nes_palette_arbiter.sv
// tb/tb_nes_palette_arbiter.sv - randomized self-checking bench for nes_palette_arbiter
module tb_nes_palette_arbiter;
   import nes_ppu_pkg::*;

   localparam int MAX_WAIT = 341;

   logic       ppu_clock;
   logic       reset_n;
   logic       rendering_enabled;
   logic       render_valid;
   logic [4:0] render_index;
   logic [7:0] x;
   logic [7:0] y;
   logic       vga_we;
   logic       vga_swap_buffers;
   logic [5:0] nes_color;
   logic [7:0] x_out;
   logic [7:0] y_out;
   logic       vga_we_out;
   logic       vga_swap_buffers_out;
   logic       busy;

   nes_palette_arbiter_if bus();

   nes_palette_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(9)) dut (
      .ppu_clock            (ppu_clock),
      .reset_n              (reset_n),
      .rendering_enabled    (rendering_enabled),
      .render_valid         (render_valid),
      .render_index         (render_index),
      .x                    (x),
      .y                    (y),
      .vga_we               (vga_we),
      .vga_swap_buffers     (vga_swap_buffers),
      .cpu                  (bus),
      .nes_color            (nes_color),
      .x_out                (x_out),
      .y_out                (y_out),
      .vga_we_out           (vga_we_out),
      .vga_swap_buffers_out (vga_swap_buffers_out),
      .busy                 (busy)
   );

   initial ppu_clock = 1'b0;
   always #5 ppu_clock = ~ppu_clock;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference model state
   logic [5:0] m_mem [32];
   int         m_phase;     // 0 no request, 1 request pending, 2 acknowledged
   int         m_waited;    // render slots lost while pending
   logic [5:0] m_color;
   logic [5:0] m_rdata;
   logic       m_ack;
   logic [7:0] m_x;
   logic [7:0] m_y;
   logic       m_we;
   logic       m_sw;
   int         g_mode;      // 0 render off, 1 render every cycle, 2 random, 3 directed

   function automatic logic [4:0] mir(input logic [4:0] a);
      int v;
      v = int'(a);
      if (v >= 16 && v % 4 == 0) v = v - 16;
      return 5'(v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rand_pixel();
      render_index     = 5'($urandom_range(0, 31));
      x                = 8'($urandom_range(0, 255));
      y                = 8'($urandom_range(0, 255));
      vga_we           = 1'($urandom_range(0, 1));
      vga_swap_buffers = 1'($urandom_range(0, 1));
   endtask

   task automatic tick();
      logic       slot;
      logic [4:0] ca;
      if (g_mode == 0) begin
         rendering_enabled = 1'b0;
         render_valid      = 1'($urandom_range(0, 1));
         rand_pixel();
      end else if (g_mode == 1) begin
         rendering_enabled = 1'b1;
         render_valid      = 1'b1;
         rand_pixel();
      end else if (g_mode == 2) begin
         rendering_enabled = ($urandom_range(0, 3) != 0);
         render_valid      = ($urandom_range(0, 3) != 0);
         rand_pixel();
      end
      slot  = rendering_enabled && render_valid;
      m_ack = 1'b0;
      if (!reset_n) begin
         m_phase = 0;
         m_color = '0;
         m_rdata = '0;
         m_x     = '0;
         m_y     = '0;
         m_we    = 1'b0;
         m_sw    = 1'b0;
      end else begin
         ca   = mir(bus.cpu_addr);
         m_x  = x;
         m_y  = y;
         m_we = vga_we;
         m_sw = vga_swap_buffers;
         if (m_phase == 1 && (!slot || m_waited == MAX_WAIT)) begin
            if (bus.cpu_we) begin
               m_mem[ca] = bus.cpu_wdata;
               if (slot) m_color = bus.cpu_wdata;
            end else begin
               m_rdata = m_mem[ca];
               if (slot) m_color = m_mem[ca];
            end
            m_ack   = 1'b1;
            m_phase = 2;
         end else begin
            if (slot) m_color = m_mem[mir(render_index)];
            if (m_phase == 1) m_waited++;
            else if (m_phase == 2) m_phase = 0;
            else if (bus.cpu_req) begin
               m_phase  = 1;
               m_waited = 0;
            end
         end
      end
      @(posedge ppu_clock);
      #1;
      chk("nes_color", nes_color, m_color);
      chk("x_out", x_out, m_x);
      chk("y_out", y_out, m_y);
      chk("vga_we_out", vga_we_out, m_we);
      chk("vga_swap_out", vga_swap_buffers_out, m_sw);
      chk("cpu_ack", bus.cpu_ack, m_ack);
      chk("cpu_rdata", bus.cpu_rdata, m_rdata);
      if (m_ack) bus.cpu_req = 1'b0;
   endtask

   task automatic cpu_op(input logic we, input logic [4:0] a, input logic [5:0] d, output int lat);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (bus.cpu_ack !== 1'b1 && lat < 1000);
      chk("ack_within_bound", (lat < 1000), 1);
      bus.cpu_req = 1'b0;
      tick();
   endtask

   initial begin
      int lat;
      logic [5:0] d;
      g_mode            = 3;
      reset_n           = 1'b0;
      rendering_enabled = 1'b0;
      render_valid      = 1'b0;
      render_index      = '0;
      x                 = '0;
      y                 = '0;
      vga_we            = 1'b0;
      vga_swap_buffers  = 1'b0;
      bus.cpu_req       = 1'b0;
      bus.cpu_we        = 1'b0;
      bus.cpu_addr      = '0;
      bus.cpu_wdata     = '0;
      m_waited          = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = '0;

      // Reset state
      tick();
      tick();
      chk("reset_busy", busy, 0);
      reset_n = 1'b1;

      // Fill every entry through the CPU with rendering off
      g_mode = 0;
      for (int a = 0; a < 32; a++) cpu_op(1'b1, 5'(a), 6'($urandom_range(0, 63)), lat);

      // Mirroring
      cpu_op(1'b1, 5'h14, 6'h2A, lat);
      cpu_op(1'b0, 5'h04, 6'h00, lat);
      chk("mirror_cpu_read", bus.cpu_rdata, 6'h2A);
      g_mode            = 3;
      rendering_enabled = 1'b1;
      render_valid      = 1'b1;
      render_index      = 5'h14;
      tick();
      chk("mirror_render_14", nes_color, 6'h2A);
      render_index = 5'h04;
      tick();
      chk("mirror_render_04", nes_color, 6'h2A);

      // Idle slot: two-cycle acknowledge
      g_mode = 0;
      cpu_op(1'b1, 5'h05, 6'h11, lat);
      chk("idle_ack_latency", lat, 2);
      g_mode            = 3;
      rendering_enabled = 1'b1;
      render_valid      = 1'b1;
      render_index      = 5'h05;
      tick();
      chk("idle_write_render", nes_color, 6'h11);

      // Pipeline alignment
      x                = 8'd10;
      y                = 8'd20;
      vga_we           = 1'b1;
      vga_swap_buffers = 1'b1;
      render_index     = 5'd7;
      tick();
      chk("align_x", x_out, 8'd10);
      chk("align_y", y_out, 8'd20);
      chk("align_we", vga_we_out, 1'b1);
      chk("align_swap", vga_swap_buffers_out, 1'b1);
      chk("align_color", nes_color, m_mem[7]);

      // Starvation: read then write against continuous rendering
      g_mode = 1;
      cpu_op(1'b0, 5'h03, 6'h00, lat);
      chk("starve_read_latency", lat, MAX_WAIT + 2);
      chk("starve_read_data", bus.cpu_rdata, m_mem[3]);
      cpu_op(1'b1, 5'h1D, 6'h3C, lat);
      chk("starve_write_latency", lat, MAX_WAIT + 2);

      // Random traffic
      g_mode = 2;
      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(0, 4)) tick();
         cpu_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), lat);
      end

      // Reset while a write is waiting: no ack, outputs cleared, RAM unchanged
      g_mode        = 1;
      d             = m_mem[5];
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 5'h05;
      bus.cpu_wdata = ~d;
      repeat (5) tick();
      reset_n = 1'b0;
      tick();
      chk("rst_ack", bus.cpu_ack, 0);
      chk("rst_color", nes_color, 0);
      chk("rst_x", x_out, 0);
      bus.cpu_req = 1'b0;
      reset_n     = 1'b1;
      g_mode            = 3;
      rendering_enabled = 1'b1;
      render_valid      = 1'b1;
      render_index      = 5'h05;
      tick();
      chk("rst_ram_kept", nes_color, d);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
